// File: rtl/mac_acc_fxp.sv
// Fixed-point multiply-accumulate over valid/ready vectors of operand pairs.
// Build option: define MAC_SAT_EN for saturating accumulate with a sticky ovf flag.
module mac_acc_fxp #(
   parameter int I_PREC   = 8,
   parameter int I_FRAC   = 4,
   parameter int ACC_PREC = 24,
   parameter int MAX_LEN  = 256
) (
   input  logic                         clk,
   input  logic                         reset_,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [I_PREC-1:0]            in_x,
   input  logic [I_PREC-1:0]            in_w,
   input  logic                         in_last,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [ACC_PREC-1:0]          out_acc,
   output logic [$clog2(MAX_LEN+1)-1:0] out_cnt,
   output logic                         ovf
);

   localparam int PW = 2 * I_PREC;
   localparam int CW = $clog2(MAX_LEN + 1);

   if (ACC_PREC < PW || I_FRAC > I_PREC) begin : g_bad_cfg
      $error("mac_acc_fxp: ACC_PREC must be >= 2*I_PREC and I_FRAC <= I_PREC");
   end

   typedef enum logic [1:0] {IDLE, ACC, FLUSH, DONE} state_t;

   state_t                     state_q, state_d;
   logic signed [ACC_PREC-1:0] acc_q, acc_d;
   logic signed [ACC_PREC-1:0] prod_q, prod_d;
   logic                       pvld_q, pvld_d;
   logic [CW-1:0]              cnt_q, cnt_d;
   logic                       ovf_q, ovf_d;

   logic signed [PW-1:0]       xs, ws, mul;
   logic signed [ACC_PREC:0]   sum;
   logic [CW-1:0]              cnt_inc;
   logic                       accept;

   always_comb begin
      xs  = PW'($signed(in_x));
      ws  = PW'($signed(in_w));
      mul = xs * ws;
      sum = (ACC_PREC+1)'(acc_q) + (ACC_PREC+1)'(prod_q);
   end

   assign in_ready  = reset_ && (state_q == IDLE || state_q == ACC);
   assign out_valid = reset_ && (state_q == DONE);
   assign accept    = in_valid && in_ready;
   assign cnt_inc   = cnt_q + CW'(1);
   assign out_acc   = acc_q;
   assign out_cnt   = cnt_q;
   assign ovf       = ovf_q;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      prod_d  = prod_q;
      pvld_d  = 1'b0;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;

      if (accept) begin
         prod_d = ACC_PREC'(mul);
         pvld_d = 1'b1;
         cnt_d  = cnt_inc;
      end

      // the product registered last cycle lands in the accumulator now
      if (pvld_q) begin
`ifdef MAC_SAT_EN
         if (sum[ACC_PREC] != sum[ACC_PREC-1]) begin
            acc_d = sum[ACC_PREC] ? {1'b1, {(ACC_PREC-1){1'b0}}}
                                  : {1'b0, {(ACC_PREC-1){1'b1}}};
            ovf_d = 1'b1;
         end else begin
            acc_d = sum[ACC_PREC-1:0];
         end
`else
         acc_d = sum[ACC_PREC-1:0];
`endif
      end

      unique case (state_q)
         IDLE, ACC: begin
            if (accept) begin
               state_d = (in_last || cnt_inc == CW'(MAX_LEN)) ? FLUSH : ACC;
            end
         end
         FLUSH: state_d = DONE;
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
               acc_d   = '0;
               cnt_d   = '0;
               ovf_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_) begin
         state_q <= IDLE;
         acc_q   <= '0;
         prod_q  <= '0;
         pvld_q  <= 1'b0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         prod_q  <= prod_d;
         pvld_q  <= pvld_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

endmodule

// File: tb/tb_mac_acc_fxp.sv
// Directed bench for mac_acc_fxp: default, 16-bit accumulator and MAX_LEN=4 builds.
module tb_mac_acc_fxp;

   logic       clk = 1'b0;
   logic       in_valid, in_last, out_ready;
   logic [7:0] in_x, in_w;
   logic       rst_a, rst_b, rst_c;

   logic        a_in_ready, a_out_valid, a_ovf;
   logic [23:0] a_acc;
   logic [8:0]  a_cnt;
   logic        b_in_ready, b_out_valid, b_ovf;
   logic [15:0] b_acc;
   logic [8:0]  b_cnt;
   logic        c_in_ready, c_out_valid, c_ovf;
   logic [23:0] c_acc;
   logic [2:0]  c_cnt;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   mac_acc_fxp dut_a (
      .clk(clk), .reset_(rst_a), .in_valid(in_valid), .in_ready(a_in_ready),
      .in_x(in_x), .in_w(in_w), .in_last(in_last), .out_valid(a_out_valid),
      .out_ready(out_ready), .out_acc(a_acc), .out_cnt(a_cnt), .ovf(a_ovf));

   mac_acc_fxp #(.ACC_PREC(16)) dut_b (
      .clk(clk), .reset_(rst_b), .in_valid(in_valid), .in_ready(b_in_ready),
      .in_x(in_x), .in_w(in_w), .in_last(in_last), .out_valid(b_out_valid),
      .out_ready(out_ready), .out_acc(b_acc), .out_cnt(b_cnt), .ovf(b_ovf));

   mac_acc_fxp #(.MAX_LEN(4)) dut_c (
      .clk(clk), .reset_(rst_c), .in_valid(in_valid), .in_ready(c_in_ready),
      .in_x(in_x), .in_w(in_w), .in_last(in_last), .out_valid(c_out_valid),
      .out_ready(out_ready), .out_acc(c_acc), .out_cnt(c_cnt), .ovf(c_ovf));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      in_valid = 0; in_last = 0; out_ready = 1; in_x = 0; in_w = 0;
      rst_a = 0; rst_b = 0; rst_c = 0;
      step(); step();
      chk("rst_in_ready", 32'(a_in_ready), 32'd0);
      chk("rst_out_valid", 32'(a_out_valid), 32'd0);

      rst_a = 1; #1;
      chk("rel_in_ready", 32'(a_in_ready), 32'd1);
      chk("rel_acc", 32'(a_acc), 32'd0);
      chk("rel_cnt", 32'(a_cnt), 32'd0);
      chk("rel_ovf", 32'(a_ovf), 32'd0);

      // three beats of 1.0 * 2.0
      in_valid = 1; in_x = 8'h10; in_w = 8'h20; in_last = 0;
      step(); step();
      in_last = 1;
      step();
      in_valid = 0; in_last = 0;
      chk("v1_flush_valid", 32'(a_out_valid), 32'd0);
      chk("v1_flush_ready", 32'(a_in_ready), 32'd0);
      step();
      chk("v1_valid", 32'(a_out_valid), 32'd1);
      chk("v1_acc", 32'(a_acc), 32'h000600);
      chk("v1_cnt", 32'(a_cnt), 32'd3);
      chk("v1_ovf", 32'(a_ovf), 32'd0);
      step();
      chk("v1_hs_valid", 32'(a_out_valid), 32'd0);
      chk("v1_hs_ready", 32'(a_in_ready), 32'd1);
      chk("v1_hs_acc", 32'(a_acc), 32'd0);
      chk("v1_hs_cnt", 32'(a_cnt), 32'd0);

      // single beat -1.0 * 1.0, then downstream stall
      in_valid = 1; in_x = 8'hF0; in_w = 8'h10; in_last = 1;
      step();
      in_valid = 0; in_last = 0;
      chk("v2_flush_ready", 32'(a_in_ready), 32'd0);
      chk("v2_flush_valid", 32'(a_out_valid), 32'd0);
      out_ready = 0;
      step();
      chk("v2_valid", 32'(a_out_valid), 32'd1);
      chk("v2_acc", 32'(a_acc), 32'hFFFF00);
      chk("v2_cnt", 32'(a_cnt), 32'd1);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("stall_valid", 32'(a_out_valid), 32'd1);
         chk("stall_acc", 32'(a_acc), 32'hFFFF00);
         chk("stall_cnt", 32'(a_cnt), 32'd1);
         chk("stall_ready", 32'(a_in_ready), 32'd0);
      end
      out_ready = 1;
      step();
      chk("v2_hs_valid", 32'(a_out_valid), 32'd0);
      chk("v2_hs_acc", 32'(a_acc), 32'd0);
      chk("v2_hs_ready", 32'(a_in_ready), 32'd1);

      // reset in the middle of a vector
      in_valid = 1; in_x = 8'h10; in_w = 8'h20; in_last = 0;
      step(); step();
      in_valid = 0; rst_a = 0; #1;
      chk("mid_rst_ready", 32'(a_in_ready), 32'd0);
      chk("mid_rst_valid", 32'(a_out_valid), 32'd0);
      step();
      rst_a = 1; #1;
      chk("post_rst_acc", 32'(a_acc), 32'd0);
      chk("post_rst_cnt", 32'(a_cnt), 32'd0);
      chk("post_rst_ovf", 32'(a_ovf), 32'd0);
      chk("post_rst_ready", 32'(a_in_ready), 32'd1);
      in_valid = 1; in_x = 8'h20; in_w = 8'h20; in_last = 1;
      step();
      in_valid = 0; in_last = 0;
      step();
      chk("v3_valid", 32'(a_out_valid), 32'd1);
      chk("v3_acc", 32'(a_acc), 32'h000400);
      chk("v3_cnt", 32'(a_cnt), 32'd1);
      step();

      // 16-bit accumulator overflow
      rst_a = 0; rst_b = 1; #1;
      in_valid = 1; in_x = 8'h80; in_w = 8'h80; in_last = 0;
      step();
      in_last = 1;
      step();
      in_valid = 0; in_last = 0;
      step();
      chk("sat_valid", 32'(b_out_valid), 32'd1);
      chk("sat_cnt", 32'(b_cnt), 32'd2);
`ifdef MAC_SAT_EN
      chk("sat_acc", 32'(b_acc), 32'h7FFF);
      chk("sat_ovf", 32'(b_ovf), 32'd1);
`else
      chk("wrap_acc", 32'(b_acc), 32'h8000);
      chk("wrap_ovf", 32'(b_ovf), 32'd0);
`endif
      step();
      chk("sat_hs_ovf", 32'(b_ovf), 32'd0);
      chk("sat_hs_acc", 32'(b_acc), 32'd0);

      // forced end at MAX_LEN=4
      rst_b = 0; rst_c = 1; #1;
      in_valid = 1; in_x = 8'h10; in_w = 8'h10; in_last = 0;
      for (int i = 0; i < 4; i++) begin
         chk("max_ready", 32'(c_in_ready), 32'd1);
         step();
      end
      chk("max_flush_ready", 32'(c_in_ready), 32'd0);
      step();
      chk("max_done_ready", 32'(c_in_ready), 32'd0);
      chk("max_valid", 32'(c_out_valid), 32'd1);
      chk("max_cnt", 32'(c_cnt), 32'd4);
      chk("max_acc", 32'(c_acc), 32'h000400);
      step();
      chk("max_hs_ready", 32'(c_in_ready), 32'd1);
      chk("max_hs_cnt", 32'(c_cnt), 32'd0);
      step();
      in_last = 1;
      step();
      in_valid = 0; in_last = 0;
      step();
      chk("tail_valid", 32'(c_out_valid), 32'd1);
      chk("tail_cnt", 32'(c_cnt), 32'd2);
      chk("tail_acc", 32'(c_acc), 32'h000200);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
